freelist_rls_queue: RTL and testbench
=====================================

FREELIST_RLS_QUEUE -- requirements
Module: freelist_rls_queue

Interface
REQ-001 Parameter DEPTH, default 16, queue entries; SHALL be a power of two, >= 8.
REQ-002 Parameter PW, default 6, physical-index width.
REQ-003 clock  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 io_in_vld_0..3  input  1 each  commit lanes carrying a physical index to free.
REQ-006 io_in_pidx_0..3  input  PW each  physical index per commit lane.
REQ-007 io_in_rdy  output  1  queue accepts a commit group this cycle.
REQ-008 io_busy  input  1  freelist busy; no release issued while high.
REQ-009 io_rls_0..3  output  1 each  release strobe per lane to freelist.
REQ-010 io_rls_pidx_0..3  output  PW each  released index per lane.
REQ-011 io_count  output  log2(DEPTH)+1  occupied entries.
REQ-012 io_empty  output  1  io_count == 0.

Function
REQ-013 io_in_rdy SHALL be combinational: 1 iff (DEPTH - io_count) >= 4.
REQ-014 Enqueue fires when io_in_rdy=1; each lane with vld=1 and pidx != 0 is an entry; lanes with vld=0 or pidx=0 are dropped.
REQ-015 Entries SHALL be written contiguously at the tail in lane order 0..3, skipping dropped lanes (compaction).
REQ-016 When io_in_rdy=0, inputs SHALL be ignored; upstream holds the group; no partial acceptance.
REQ-017 Dequeue fires when io_busy=0 and io_count>0: removes min(io_count, 4) entries from the head.
REQ-018 Dequeued entries SHALL appear on io_rls_*/io_rls_pidx_* one cycle later (registered), packed into lanes 0..k-1 in FIFO order; lanes k..3 have rls=0, pidx=0.
REQ-019 In a cycle without dequeue, registered outputs next cycle SHALL be all rls=0, pidx=0 (one-shot strobes, no hold).
REQ-020 io_busy sampled in cycle N blocks only the dequeue in cycle N; registered outputs already launched are unaffected.
REQ-021 Enqueue and dequeue in the same cycle SHALL both occur; io_count_next = io_count + n_enq - n_deq.
REQ-022 No bypass: an entry enqueued in cycle N is dequeued at earliest in cycle N+1, visible on outputs in N+2.
REQ-023 Dequeue count in cycle N SHALL use io_count before that cycle's enqueue.
REQ-024 Head/tail pointers are log2(DEPTH) bits, wrap modulo DEPTH; multi-entry writes/reads SHALL wrap correctly across the end.
REQ-025 io_count SHALL never exceed DEPTH nor underflow; REQ-013 guarantees this.
REQ-026 Per-lane pidx order and values SHALL be preserved exactly; duplicates are not checked.

Reset
REQ-027 While reset=0: head=0, tail=0, io_count=0, io_empty=1, all io_rls_*=0, all io_rls_pidx_*=0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries and any pending registered release.
REQ-029 First enqueue permitted on the first rising edge with reset=1.

Verification
REQ-030 Reset, then one group vld=1111, pidx=5,6,7,8, busy=0 -> io_count 4 next cycle; following cycle io_rls=1111, pidx=5,6,7,8; io_count 0.
REQ-031 vld=1011, pidx=9,x,0,12 -> only 9 and 12 enqueued (lane 1 invalid, lane 2 pidx 0); release lanes 0,1 = 9,12; lanes 2,3 = 0.
REQ-032 busy=1, four full groups -> io_count 16, io_in_rdy=0; fifth group ignored; busy=0 -> four release cycles in order, io_count 16,12,8,4,0.
REQ-033 Pointer wrap: fill 14, drain 12, enqueue 4 (tail wraps from 14 to 2) -> release order matches enqueue order across the wrap.
REQ-034 Simultaneous: io_count=3, enqueue 4, busy=0 -> 3 released, io_count 4 next cycle; new entries released the cycle after.
REQ-035 reset=0 asynchronously while io_count=10 and release strobes valid -> outputs 0 immediately, io_count 0, no stale release after reset deasserts.

Source files
------------

// File: rtl/freelist_rls_queue.sv
// Release queue between commit and the freelist: compacts up to four freed physical
// indices per cycle into a circular buffer and returns up to four per cycle when the freelist is idle.
module freelist_rls_queue #(
    parameter int DEPTH = 16,
    parameter int PW    = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_in_vld_0,
    input  logic                     io_in_vld_1,
    input  logic                     io_in_vld_2,
    input  logic                     io_in_vld_3,
    input  logic [PW-1:0]            io_in_pidx_0,
    input  logic [PW-1:0]            io_in_pidx_1,
    input  logic [PW-1:0]            io_in_pidx_2,
    input  logic [PW-1:0]            io_in_pidx_3,
    output logic                     io_in_rdy,
    input  logic                     io_busy,
    output logic                     io_rls_0,
    output logic                     io_rls_1,
    output logic                     io_rls_2,
    output logic                     io_rls_3,
    output logic [PW-1:0]            io_rls_pidx_0,
    output logic [PW-1:0]            io_rls_pidx_1,
    output logic [PW-1:0]            io_rls_pidx_2,
    output logic [PW-1:0]            io_rls_pidx_3,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH - 4);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;

    logic [3:0]    in_vld;
    logic [PW-1:0] in_pidx [4];
    logic [3:0]    keep;
    logic [2:0]    off [4];
    logic [2:0]    n_enq, n_deq, n_enq_eff, n_deq_eff;
    logic          enq, deq;
    logic [3:0]    lane_rel;
    logic [PW-1:0] rd_pidx [4];

    logic [3:0]    rls_q;
    logic [PW-1:0] rls_pidx_q [4];

    assign in_vld     = {io_in_vld_3, io_in_vld_2, io_in_vld_1, io_in_vld_0};
    assign in_pidx[0] = io_in_pidx_0;
    assign in_pidx[1] = io_in_pidx_1;
    assign in_pidx[2] = io_in_pidx_2;
    assign in_pidx[3] = io_in_pidx_3;

    // Whole groups only: room for four guarantees any group fits, so no partial accept.
    assign io_in_rdy = (count <= RDY_MAX);
    assign enq       = io_in_rdy;
    assign deq       = !io_busy && (count != '0);

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        keep   = '0;
        off[0] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            keep[i] = in_vld[i] && (in_pidx[i] != '0);
        end
        for (int i = 1; i < 4; i++) begin
            off[i] = off[i-1] + {2'b00, keep[i-1]};
        end
        n_enq = off[3] + {2'b00, keep[3]};
    end

    // Dequeue size is taken from the pre-enqueue count, so new entries never bypass.
    always_comb begin
        n_deq    = (count >= (AW+1)'(4)) ? 3'd4 : count[2:0];
        lane_rel = '0;
        for (int i = 0; i < 4; i++) begin
            lane_rel[i] = deq && (3'(i) < n_deq);
            rd_pidx[i]  = mem[head + AW'(i)];
        end
    end

    assign n_enq_eff = enq ? n_enq : 3'd0;
    assign n_deq_eff = deq ? n_deq : 3'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_deq_eff);
            tail  <= tail + AW'(n_enq_eff);
            count <= count + (AW+1)'(n_enq_eff) - (AW+1)'(n_deq_eff);
        end
    end

    // NOTE: storage has no reset; occupancy is tracked by count, so stale contents are never read.
    always_ff @(posedge clock) begin
        if (enq) begin
            for (int i = 0; i < 4; i++) begin
                if (keep[i]) begin
                    mem[tail + AW'(off[i])] <= in_pidx[i];
                end
            end
        end
    end

    // One-shot release strobes; unused lanes are driven to zero rather than holding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rls_q <= '0;
            for (int i = 0; i < 4; i++) begin
                rls_pidx_q[i] <= '0;
            end
        end else begin
            rls_q <= lane_rel;
            for (int i = 0; i < 4; i++) begin
                rls_pidx_q[i] <= lane_rel[i] ? rd_pidx[i] : '0;
            end
        end
    end

    assign io_rls_0      = rls_q[0];
    assign io_rls_1      = rls_q[1];
    assign io_rls_2      = rls_q[2];
    assign io_rls_3      = rls_q[3];
    assign io_rls_pidx_0 = rls_pidx_q[0];
    assign io_rls_pidx_1 = rls_pidx_q[1];
    assign io_rls_pidx_2 = rls_pidx_q[2];
    assign io_rls_pidx_3 = rls_pidx_q[3];
    assign io_count      = count;
    assign io_empty      = (count == '0);

endmodule

// File: tb/tb_freelist_rls_queue.sv
// Directed bench for freelist_rls_queue: a behavioural occupancy model plus a FIFO
// scoreboard of expected released indices, checked by a negedge release monitor.
module tb_freelist_rls_queue;

    localparam int DEPTH = 16;
    localparam int PW    = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_in_vld_0, io_in_vld_1, io_in_vld_2, io_in_vld_3;
    logic [PW-1:0] io_in_pidx_0, io_in_pidx_1, io_in_pidx_2, io_in_pidx_3;
    logic          io_in_rdy;
    logic          io_busy;
    logic          io_rls_0, io_rls_1, io_rls_2, io_rls_3;
    logic [PW-1:0] io_rls_pidx_0, io_rls_pidx_1, io_rls_pidx_2, io_rls_pidx_3;
    logic [4:0]    io_count;
    logic          io_empty;

    freelist_rls_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clock(clock), .reset(reset),
        .io_in_vld_0(io_in_vld_0), .io_in_vld_1(io_in_vld_1),
        .io_in_vld_2(io_in_vld_2), .io_in_vld_3(io_in_vld_3),
        .io_in_pidx_0(io_in_pidx_0), .io_in_pidx_1(io_in_pidx_1),
        .io_in_pidx_2(io_in_pidx_2), .io_in_pidx_3(io_in_pidx_3),
        .io_in_rdy(io_in_rdy), .io_busy(io_busy),
        .io_rls_0(io_rls_0), .io_rls_1(io_rls_1), .io_rls_2(io_rls_2), .io_rls_3(io_rls_3),
        .io_rls_pidx_0(io_rls_pidx_0), .io_rls_pidx_1(io_rls_pidx_1),
        .io_rls_pidx_2(io_rls_pidx_2), .io_rls_pidx_3(io_rls_pidx_3),
        .io_count(io_count), .io_empty(io_empty)
    );

    always #5 clock = ~clock;

    int            checks    = 0;
    int            errors    = 0;
    int            m_count   = 0;
    int            exp_rel_n = 0;
    logic [PW-1:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Release monitor: strobes must be packed low, match the scoreboard head, and number as predicted.
    logic [3:0]    mon_r;
    logic [PW-1:0] mon_p [4];
    logic [PW-1:0] mon_e;
    int            mon_n;
    bit            mon_gap;

    always @(negedge clock) begin
        mon_r    = {io_rls_3, io_rls_2, io_rls_1, io_rls_0};
        mon_p[0] = io_rls_pidx_0;
        mon_p[1] = io_rls_pidx_1;
        mon_p[2] = io_rls_pidx_2;
        mon_p[3] = io_rls_pidx_3;
        mon_n    = 0;
        mon_gap  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mon_r[i] === 1'b1) begin
                check("rls_packed", mon_gap, 0);
                check("rls_sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("rls_pidx", mon_p[i], mon_e);
                end
                mon_n++;
            end else begin
                mon_gap = 1'b1;
                check("rls_idle_lane", {mon_r[i], mon_p[i]}, 0);
            end
        end
        check("rls_count", mon_n, exp_rel_n);
    end

    // One clock of stimulus: predicts ready, pushes accepted entries, then checks count/empty.
    task automatic cycle(input logic [3:0] v, input int a, input int b, input int c, input int d,
                         input logic bz);
        int p [4];
        int nenq, ndeq;
        bit rdy_m;
        p = '{a, b, c, d};
        io_in_vld_0  = v[0];
        io_in_vld_1  = v[1];
        io_in_vld_2  = v[2];
        io_in_vld_3  = v[3];
        io_in_pidx_0 = PW'(p[0]);
        io_in_pidx_1 = PW'(p[1]);
        io_in_pidx_2 = PW'(p[2]);
        io_in_pidx_3 = PW'(p[3]);
        io_busy      = bz;
        rdy_m = (DEPTH - m_count) >= 4;
        #1;
        check("in_rdy", io_in_rdy, rdy_m);
        ndeq = bz ? 0 : ((m_count < 4) ? m_count : 4);
        nenq = 0;
        if (rdy_m) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i] && p[i] != 0) begin
                    sb.push_back(PW'(p[i]));
                    nenq++;
                end
            end
        end
        m_count = m_count + nenq - ndeq;
        @(posedge clock);
        #1;
        exp_rel_n = ndeq;
        check("count", io_count, m_count);
        check("empty", io_empty, m_count == 0);
    endtask

    task automatic idle(input logic bz);
        cycle(4'b0000, 0, 0, 0, 0, bz);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_count != 0 && guard < 40) begin
            idle(1'b0);
            guard++;
        end
        check("drain_bound", guard < 40, 1);
        idle(1'b0);
        idle(1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rls"}, {io_rls_3, io_rls_2, io_rls_1, io_rls_0}, 0);
        check({tag, "_pidx"}, {io_rls_pidx_3, io_rls_pidx_2, io_rls_pidx_1, io_rls_pidx_0}, 0);
        check({tag, "_count"}, io_count, 0);
        check({tag, "_empty"}, io_empty, 1);
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        sb.delete();
        exp_rel_n = 0;
        m_count   = 0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        {io_in_vld_3, io_in_vld_2, io_in_vld_1, io_in_vld_0} = '0;
        {io_in_pidx_3, io_in_pidx_2, io_in_pidx_1, io_in_pidx_0} = '0;
        io_busy = 1'b0;

        apply_reset();

        // Full group straight after reset, released two cycles later.
        cycle(4'b1111, 5, 6, 7, 8, 1'b0);
        check("full_group_count", io_count, 4);
        idle(1'b0);
        check("full_group_drained", io_count, 0);
        drain();

        // Compaction: lane 1 invalid, lane 2 carries index 0.
        cycle(4'b1101, 9, 3, 0, 12, 1'b0);
        check("compact_count", io_count, 2);
        drain();

        // Fill to capacity while busy; a fifth group must be ignored.
        cycle(4'b1111, 1, 2, 3, 4, 1'b1);
        cycle(4'b1111, 5, 6, 7, 8, 1'b1);
        cycle(4'b1111, 9, 10, 11, 12, 1'b1);
        cycle(4'b1111, 13, 14, 15, 16, 1'b1);
        check("full_count", io_count, 16);
        check("full_rdy", io_in_rdy, 0);
        cycle(4'b1111, 20, 21, 22, 23, 1'b1);
        check("full_ignored", io_count, 16);
        idle(1'b0);
        check("drain_12", io_count, 12);
        idle(1'b0);
        check("drain_8", io_count, 8);
        idle(1'b0);
        check("drain_4", io_count, 4);
        idle(1'b0);
        check("drain_0", io_count, 0);
        drain();

        // Ready boundary: 12 occupied still ready, 13 not.
        cycle(4'b1111, 17, 18, 19, 20, 1'b1);
        cycle(4'b1111, 21, 22, 23, 24, 1'b1);
        cycle(4'b1111, 25, 26, 27, 28, 1'b1);
        check("rdy_at_12", io_in_rdy, 1);
        cycle(4'b0001, 29, 0, 0, 0, 1'b1);
        check("rdy_at_13", io_in_rdy, 0);
        cycle(4'b1111, 40, 41, 42, 43, 1'b1);
        check("ignored_at_13", io_count, 13);
        drain();

        // Pointer wrap: fill 14, drain 12, enqueue 4 across the end of storage.
        apply_reset();
        cycle(4'b1111, 1, 2, 3, 4, 1'b1);
        cycle(4'b1111, 5, 6, 7, 8, 1'b1);
        cycle(4'b1111, 9, 10, 11, 12, 1'b1);
        cycle(4'b0011, 13, 14, 0, 0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        check("wrap_pre_count", io_count, 2);
        cycle(4'b1111, 30, 31, 32, 33, 1'b1);
        check("wrap_count", io_count, 6);
        drain();

        // Simultaneous enqueue and dequeue from three occupied entries.
        cycle(4'b0111, 34, 35, 36, 0, 1'b1);
        check("simul_pre", io_count, 3);
        cycle(4'b1111, 37, 38, 39, 40, 1'b0);
        check("simul_count", io_count, 4);
        drain();

        // Asynchronous reset with ten queued entries and strobes in flight.
        cycle(4'b1111, 41, 42, 43, 44, 1'b1);
        cycle(4'b1111, 45, 46, 47, 48, 1'b1);
        cycle(4'b1111, 49, 50, 51, 52, 1'b1);
        cycle(4'b0011, 53, 54, 0, 0, 1'b0);
        check("pre_reset_count", io_count, 10);
        check("pre_reset_strobe", {io_rls_0, io_rls_pidx_0}, {1'b1, 6'd41});
        apply_reset();
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        check_outputs_zero("post_reset");

        check("sb_empty_at_end", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
